// File: rtl/sprite_palette_engine_if.sv
// sprite_palette_engine_if
//   Bundles the pixel lookup request, palette write port, frame/flash
//   controls and the colored pixel result of sprite_palette_engine.
//   master: sprite address generator / control side (drives requests)
//   slave : the palette engine itself
interface sprite_palette_engine_if #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned NUM_PAL = 4
);
    localparam int unsigned PAL_W = $clog2(NUM_PAL);

    // lookup request
    logic                 pix_valid_in;
    logic [PAL_W-1:0]     pal_sel;
    logic [INDEX_W-1:0]   index;
    logic [1:0]           dim;
    // palette write port
    logic                 wr_en;
    logic [PAL_W-1:0]     wr_pal;
    logic [INDEX_W-1:0]   wr_idx;
    logic [3*COLOR_W-1:0] wr_data;
    // effect timing
    logic                 frame_start;
    logic                 flash_start;
    // result
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic                 transparent;
    logic                 pix_valid_out;
    logic                 flash_busy;

    modport master (
        output pix_valid_in, pal_sel, index, dim,
        output wr_en, wr_pal, wr_idx, wr_data,
        output frame_start, flash_start,
        input  red, green, blue, transparent, pix_valid_out, flash_busy
    );

    modport slave (
        input  pix_valid_in, pal_sel, index, dim,
        input  wr_en, wr_pal, wr_idx, wr_data,
        input  frame_start, flash_start,
        output red, green, blue, transparent, pix_valid_out, flash_busy
    );
endinterface

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine
//   Multi-bank writable sprite palette. A {pal_sel,index} lookup passes a
//   2-stage pipeline (RAM read, then color shaping) and emerges as RGB plus a
//   transparency flag, with per-pixel dimming and a frame-timed hit flash.
//   Ports:
//     Clk, Reset : clock, synchronous active-high reset
//     bus        : sprite_palette_engine_if.slave
//                  lookup (pix_valid_in/pal_sel/index/dim), write port
//                  (wr_en/wr_pal/wr_idx/wr_data), frame_start/flash_start,
//                  result (red/green/blue/transparent/pix_valid_out),
//                  flash_busy
module sprite_palette_engine #(
    parameter int unsigned INDEX_W      = 4,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned NUM_PAL      = 4,
    parameter int unsigned TRANSP_IDX   = 1,
    parameter logic [3*COLOR_W-1:0] FLASH_RGB = 12'hFFF,
    parameter int unsigned FLASH_FRAMES = 4,
    parameter int unsigned FLASH_BLINKS = 3
) (
    input logic Clk,
    input logic Reset,
    sprite_palette_engine_if.slave bus
);
    localparam int unsigned PAL_W = $clog2(NUM_PAL);
    localparam int unsigned DEPTH = NUM_PAL << INDEX_W;
    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned PH_W  = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned TG_W  = $clog2(2 * FLASH_BLINKS);

    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(FLASH_FRAMES - 1);
    localparam logic [TG_W-1:0] TG_LOAD = TG_W'(2 * FLASH_BLINKS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} flash_state_t;

    // palette storage (never reset)
    logic [RGB_W-1:0] mem [DEPTH];
    logic [RGB_W-1:0] s1_rgb;

    // stage 1
    logic             s1_valid;
    logic [1:0]       s1_dim;
    logic             s1_transp;

    // stage 2 / outputs
    logic [RGB_W-1:0] out_rgb;
    logic             out_transp;
    logic             out_valid;

    // flash FSM
    flash_state_t     state;
    logic [PH_W-1:0]  phase_cnt;
    logic [TG_W-1:0]  toggles;
    logic             busy;

    // Read and write share one edge; the read sees the pre-write word.
    always_ff @(posedge Clk) begin
        if (bus.wr_en)
            mem[{bus.wr_pal, bus.wr_idx}] <= bus.wr_data;
        s1_rgb <= mem[{bus.pal_sel, bus.index}];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid   <= 1'b0;
            s1_dim     <= '0;
            s1_transp  <= 1'b0;
            out_rgb    <= '0;
            out_transp <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            s1_valid  <= bus.pix_valid_in;
            s1_dim    <= bus.dim;
            s1_transp <= (bus.index == INDEX_W'(TRANSP_IDX));

            out_valid <= s1_valid;
            // Outputs only move on a valid pixel; otherwise they hold.
            if (s1_valid) begin
                out_transp <= s1_transp;
                if (s1_transp)
                    out_rgb <= s1_rgb;
                else if (state == ON)
                    out_rgb <= FLASH_RGB;
                else
                    out_rgb <= {s1_rgb[3*COLOR_W-1 -: COLOR_W] >> s1_dim,
                                s1_rgb[2*COLOR_W-1 -: COLOR_W] >> s1_dim,
                                s1_rgb[COLOR_W-1   -: COLOR_W] >> s1_dim};
            end
        end
    end

    // ON/OFF phases of FLASH_FRAMES frames each; the last phase is OFF.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            toggles   <= '0;
            busy      <= 1'b0;
        end else if (bus.flash_start) begin
            state     <= ON;
            phase_cnt <= PH_LOAD;
            toggles   <= TG_LOAD;
            busy      <= 1'b1;
        end else if (bus.frame_start && state != IDLE) begin
            if (phase_cnt != '0) begin
                phase_cnt <= phase_cnt - 1'b1;
            end else if (toggles == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                state     <= (state == ON) ? OFF : ON;
                toggles   <= toggles - 1'b1;
                phase_cnt <= PH_LOAD;
            end
        end
    end

    assign bus.red           = out_rgb[3*COLOR_W-1 -: COLOR_W];
    assign bus.green         = out_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue          = out_rgb[COLOR_W-1   -: COLOR_W];
    assign bus.transparent   = out_transp;
    assign bus.pix_valid_out = out_valid;
    assign bus.flash_busy    = busy;
endmodule
